// File: rtl/serializer_pkg.sv
// Shared types and constants for the serializer word scheduler.
// Imported by the interface, the round-robin arbiter and the top.
package serializer_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam logic [7:0] IDLE_WORD_DEFAULT = 8'b1010_1010;

    // A single requester still needs a one-bit SRC_ID
    function automatic int clog2Min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serializer_arbiter_if.sv
// Requester-side bus of the serializer arbiter: word handshake plus the
// registered word presented to the serializer.
interface serializer_arbiter_if
    import serializer_pkg::*;
#(
    parameter int INPUTS_NUM = 8,
    parameter int REQ_NUM    = 4,
    parameter int ID_W       = clog2Min1(REQ_NUM)
);
    logic                          ENABLE;
    logic [REQ_NUM-1:0]            REQ_VALID;
    logic [REQ_NUM-1:0]            REQ_LAST;
    logic [REQ_NUM*INPUTS_NUM-1:0] REQ_DATA;
    logic [REQ_NUM-1:0]            REQ_READY;
    logic [INPUTS_NUM-1:0]         PAR_OUT;
    logic                          WORD_LOAD;
    logic                          WORD_VALID;
    logic [ID_W-1:0]               SRC_ID;

    modport master (
        output ENABLE, REQ_VALID, REQ_LAST, REQ_DATA,
        input  REQ_READY, PAR_OUT, WORD_LOAD, WORD_VALID, SRC_ID
    );

    modport slave (
        input  ENABLE, REQ_VALID, REQ_LAST, REQ_DATA,
        output REQ_READY, PAR_OUT, WORD_LOAD, WORD_VALID, SRC_ID
    );

endinterface

// File: rtl/serializer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above
// ptr_i, wrapping modulo REQ_NUM.
module rr_arbiter #(
    parameter int REQ_NUM = 4,
    parameter int ID_W    = 2
) (
    input  logic [REQ_NUM-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [REQ_NUM-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o
);

    int   cand;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < REQ_NUM; k++) begin
            cand = (int'(ptr_i) + k) % REQ_NUM;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/serializer_arbiter.sv
// Word-slot scheduler sharing one serializer between REQ_NUM requesters,
// granting whole packets round-robin and filling empty slots with IDLE_WORD.
module serializer_arbiter
    import serializer_pkg::*;
#(
    parameter int                    INPUTS_NUM = 8,
    parameter int                    REQ_NUM    = 4,
    parameter logic [INPUTS_NUM-1:0] IDLE_WORD  = INPUTS_NUM'(IDLE_WORD_DEFAULT),
    parameter int                    ID_W       = clog2Min1(REQ_NUM)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    serializer_arbiter_if.slave  bus
);

    localparam int              PH_W    = $clog2(INPUTS_NUM);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(INPUTS_NUM - 1);

    arb_state_e            state_q;
    logic [PH_W-1:0]       phase_q;
    logic [ID_W-1:0]       rrPtr_q;
    logic [ID_W-1:0]       lockId_q;
    logic [ID_W-1:0]       srcId_q;
    logic [INPUTS_NUM-1:0] parOut_q;
    logic                  wordLoad_q;
    logic                  wordValid_q;

    logic                  slot;
    logic                  transfer;
    logic                  grantLast;
    logic [REQ_NUM-1:0]    reqMasked;
    logic [REQ_NUM-1:0]    grant;
    logic [REQ_NUM-1:0]    ready;
    logic [ID_W-1:0]       grantIdx;
    logic [ID_W-1:0]       nextPtr;
    logic [INPUTS_NUM-1:0] grantData;

    // While locked only the owner may win, so the pointer value is irrelevant
    always_comb begin
        reqMasked = bus.REQ_VALID;
        if (state_q == LOCKED) begin
            reqMasked = bus.REQ_VALID & (REQ_NUM'(1) << lockId_q);
        end
    end

    rr_arbiter #(
        .REQ_NUM (REQ_NUM),
        .ID_W    (ID_W)
    ) u_rrArbiter (
        .req_i   (reqMasked),
        .ptr_i   (rrPtr_q),
        .grant_o (grant),
        .idx_o   (grantIdx)
    );

    assign slot      = bus.ENABLE && (phase_q == PH_LAST);
    assign ready     = slot ? grant : '0;
    assign transfer  = |ready;
    assign grantLast = bus.REQ_LAST[grantIdx];
    assign grantData = bus.REQ_DATA[grantIdx*INPUTS_NUM +: INPUTS_NUM];
    assign nextPtr   = (grantIdx == ID_W'(REQ_NUM - 1)) ? '0 : grantIdx + 1'b1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase_q <= '0;
        end else if (bus.ENABLE) begin
            phase_q <= phase_q + 1'b1;
        end else begin
            phase_q <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ARB;
            lockId_q    <= '0;
            rrPtr_q     <= '0;
            parOut_q    <= IDLE_WORD;
            wordLoad_q  <= 1'b0;
            wordValid_q <= 1'b0;
            srcId_q     <= '0;
        end else begin
            wordLoad_q <= slot;
            if (slot) begin
                if (transfer) begin
                    parOut_q    <= grantData;
                    wordValid_q <= 1'b1;
                    srcId_q     <= grantIdx;
                    if (grantLast) begin
                        state_q <= ARB;
                        rrPtr_q <= nextPtr;
                    end else begin
                        state_q  <= LOCKED;
                        lockId_q <= grantIdx;
                    end
                end else begin
                    parOut_q    <= IDLE_WORD;
                    wordValid_q <= 1'b0;
                    srcId_q     <= '0;
                end
            end
        end
    end

    assign bus.REQ_READY  = ready;
    assign bus.PAR_OUT    = parOut_q;
    assign bus.WORD_LOAD  = wordLoad_q;
    assign bus.WORD_VALID = wordValid_q;
    assign bus.SRC_ID     = srcId_q;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed and randomized bench for serializer_arbiter against a
// packet-level reference model of slots, ownership and round-robin order.
module tb_serializer_arbiter;

    localparam int INPUTS_NUM = 8;
    localparam int REQ_NUM    = 4;
    localparam int ID_W       = 2;
    localparam logic [7:0] IDLE = 8'hAA;

    logic clk = 1'b0;
    logic rstIn;
    logic enIn;
    logic [REQ_NUM-1:0] holdOff;

    always #5 clk = ~clk;

    serializer_arbiter_if #(.INPUTS_NUM(INPUTS_NUM), .REQ_NUM(REQ_NUM), .ID_W(ID_W)) bus ();

    serializer_arbiter #(
        .INPUTS_NUM (INPUTS_NUM),
        .REQ_NUM    (REQ_NUM),
        .IDLE_WORD  (IDLE),
        .ID_W       (ID_W)
    ) dut (
        .CLK   (clk),
        .RESET (rstIn),
        .bus   (bus)
    );

    // Pending words per requester: bit 8 marks the last word of a packet
    logic [8:0] txq [REQ_NUM][$];

    logic [REQ_NUM-1:0]            drvValid;
    logic [REQ_NUM-1:0]            drvLast;
    logic [REQ_NUM*INPUTS_NUM-1:0] drvData;

    int         mPhase;
    int         mOwner;
    int         mRr;
    logic [7:0] mPar;
    logic       mWv;
    logic       mLoad;
    int         mSrc;

    int passCount;
    int checkCount;
    int loadLog[$];
    int expLog[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic applyStimulus();
        drvValid = '0;
        drvLast  = '0;
        drvData  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (txq[i].size() > 0 && !holdOff[i]) begin
                drvValid[i]             = 1'b1;
                drvLast[i]              = txq[i][0][8];
                drvData[i*INPUTS_NUM +: INPUTS_NUM] = txq[i][0][7:0];
            end
        end
        bus.ENABLE    = enIn;
        bus.REQ_VALID = drvValid;
        bus.REQ_LAST  = drvLast;
        bus.REQ_DATA  = drvData;
    endtask

    // Grant a requester only in the last cycle of a word period
    function automatic logic [REQ_NUM-1:0] expReady();
        logic [REQ_NUM-1:0] r;
        r = '0;
        if (enIn && mPhase == INPUTS_NUM - 1) begin
            if (mOwner >= 0) begin
                if (drvValid[mOwner]) r[mOwner] = 1'b1;
            end else begin
                for (int k = 0; k < REQ_NUM; k++) begin
                    if (r == '0 && drvValid[(mRr + k) % REQ_NUM]) r[(mRr + k) % REQ_NUM] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic modelReset();
        mPhase = 0;
        mOwner = -1;
        mRr    = 0;
        mPar   = IDLE;
        mWv    = 1'b0;
        mLoad  = 1'b0;
        mSrc   = 0;
    endtask

    task automatic modelStep(input logic [REQ_NUM-1:0] er);
        logic [8:0] w;
        int g;
        if (rstIn) begin
            modelReset();
            return;
        end
        mLoad = 1'b0;
        if (enIn && mPhase == INPUTS_NUM - 1) begin
            mLoad = 1'b1;
            if (er != '0) begin
                g = 0;
                for (int i = 0; i < REQ_NUM; i++) if (er[i]) g = i;
                w = txq[g].pop_front();
                mPar = w[7:0];
                mWv  = 1'b1;
                mSrc = g;
                if (w[8]) begin
                    mOwner = -1;
                    mRr    = (g + 1) % REQ_NUM;
                end else begin
                    mOwner = g;
                end
            end else begin
                mPar = IDLE;
                mWv  = 1'b0;
                mSrc = 0;
            end
        end
        mPhase = enIn ? (mPhase + 1) % INPUTS_NUM : 0;
    endtask

    // One clock: READY mid-cycle, registered outputs just after the edge
    task automatic checkOutput(input string tag);
        logic [REQ_NUM-1:0] er;
        applyStimulus();
        @(negedge clk);
        er = expReady();
        check({tag, "/ready"}, 32'(bus.REQ_READY), 32'(er));
        @(posedge clk);
        modelStep(er);
        #1;
        check({tag, "/par"},   32'(bus.PAR_OUT),    32'(mPar));
        check({tag, "/load"},  32'(bus.WORD_LOAD),  32'(mLoad));
        check({tag, "/wv"},    32'(bus.WORD_VALID), 32'(mWv));
        check({tag, "/src"},   32'(bus.SRC_ID),     32'(mSrc));
        if (bus.WORD_LOAD) loadLog.push_back((int'(bus.WORD_VALID) << 16) | (int'(bus.SRC_ID) << 8) | int'(bus.PAR_OUT));
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) checkOutput(tag);
    endtask

    task automatic runUntilPop(input int r, input int target, input string tag);
        int n;
        n = 0;
        while (txq[r].size() > target && n < 40) begin
            checkOutput(tag);
            n++;
        end
        check({tag, "/timeout"}, 32'(txq[r].size() <= target), 32'd1);
    endtask

    task automatic doReset(input int cycles);
        for (int i = 0; i < REQ_NUM; i++) txq[i].delete();
        holdOff = '0;
        rstIn   = 1'b1;
        runCycles(cycles, "reset");
        rstIn   = 1'b0;
    endtask

    task automatic compareLog(input string tag);
        check({tag, "/count"}, 32'(loadLog.size()), 32'(expLog.size()));
        for (int i = 0; i < expLog.size() && i < loadLog.size(); i++) begin
            check($sformatf("%s/word%0d", tag, i), 32'(loadLog[i]), 32'(expLog[i]));
        end
    endtask

    function automatic int ent(input int wv, input int src, input int par);
        return (wv << 16) | (src << 8) | par;
    endfunction

    initial begin
        int n;
        int loads;
        int r;
        int len;
        passCount  = 0;
        checkCount = 0;
        holdOff    = '0;
        enIn       = 1'b0;
        rstIn      = 1'b1;
        modelReset();
        applyStimulus();
        @(posedge clk);
        #1;

        // Reset values, then idle slots with no requests
        doReset(2);
        check("reset/par", 32'(bus.PAR_OUT), 32'hAA);
        enIn = 1'b1;
        loadLog.delete();
        runCycles(24, "idle");
        check("idle/loadCount", 32'(loadLog.size()), 32'd3);

        // Single-word packet from requester 1, then rr pointer at 2 favours req2 over req0
        txq[1].push_back({1'b1, 8'h3C});
        loadLog.delete();
        runCycles(8, "single");
        expLog = '{ent(1, 1, 8'h3C)};
        compareLog("single");

        txq[2].push_back({1'b0, 8'h11});
        txq[2].push_back({1'b0, 8'h22});
        txq[2].push_back({1'b1, 8'h33});
        txq[0].push_back({1'b1, 8'h5A});
        loadLog.delete();
        runCycles(32, "packet");
        expLog = '{ent(1, 2, 8'h11), ent(1, 2, 8'h22), ent(1, 2, 8'h33), ent(1, 0, 8'h5A)};
        compareLog("packet");

        // Mid-packet bubble: one idle slot, req0 must wait for the packet end
        txq[2].push_back({1'b0, 8'h44});
        txq[2].push_back({1'b0, 8'h55});
        txq[2].push_back({1'b1, 8'h66});
        txq[0].push_back({1'b1, 8'h77});
        loadLog.delete();
        runUntilPop(2, 2, "bubble");
        holdOff = 4'b0100;
        runCycles(8, "bubble");
        holdOff = '0;
        runCycles(30, "bubble");
        expLog = '{ent(1, 2, 8'h44), ent(0, 0, 8'hAA), ent(1, 2, 8'h55), ent(1, 2, 8'h66), ent(1, 0, 8'h77)};
        compareLog("bubble");

        // All four requesters streaming single-word packets from reset
        doReset(2);
        enIn = 1'b1;
        for (int rnd = 0; rnd < 2; rnd++)
            for (int i = 0; i < REQ_NUM; i++) txq[i].push_back({1'b1, 8'($urandom_range(0, 255))});
        loadLog.delete();
        runCycles(64, "stream");
        check("stream/count", 32'(loadLog.size()), 32'd8);
        for (int i = 0; i < loadLog.size() && i < 8; i++)
            check($sformatf("stream/src%0d", i), 32'((loadLog[i] >> 8) & 'hFF), 32'(i % REQ_NUM));

        // Randomized packets, bubbles and enable drops
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, REQ_NUM - 1);
                if (txq[r].size() < 6) begin
                    len = $urandom_range(1, 3);
                    for (int w = 0; w < len; w++)
                        txq[r].push_back({(w == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))});
                end
            end
            if ($urandom_range(0, 7) == 0) holdOff = 4'($urandom & $urandom);
            if (enIn && $urandom_range(0, 39) == 0) enIn = 1'b0;
            else if (!enIn && $urandom_range(0, 3) == 0) enIn = 1'b1;
            checkOutput("random");
        end

        // Reset in the middle of a packet, then a short disable window
        enIn    = 1'b1;
        holdOff = '0;
        runCycles(INPUTS_NUM * 12, "drain");
        for (int i = 0; i < REQ_NUM; i++) txq[i].delete();
        txq[3].push_back({1'b0, 8'hC1});
        txq[3].push_back({1'b0, 8'hC2});
        txq[3].push_back({1'b1, 8'hC3});
        runUntilPop(3, 2, "midrst");
        doReset(2);
        check("midrst/par", 32'(bus.PAR_OUT), 32'hAA);
        enIn  = 1'b0;
        loadLog.delete();
        runCycles(5, "disabled");
        check("disabled/loads", 32'(loadLog.size()), 32'd0);
        enIn  = 1'b1;
        n     = 0;
        loads = 0;
        while (loads == 0 && n < 20) begin
            checkOutput("reenable");
            n++;
            if (bus.WORD_LOAD) loads++;
        end
        check("reenable/latency", 32'(n), 32'(INPUTS_NUM));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
